// File: rtl/fe_arb_pkg.sv
// Shared types and helpers for the front-end stream arbiters.
package fe_arb_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_CH   = 16;
  localparam int unsigned CH_IDX_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Rotate-priority pick: first set bit of req searching last+1, last+2, ...
  // wrapping at width; last itself is reached on the final step, so a lone
  // requester is always re-selected.
  function automatic logic [MAX_CH-1:0] rr_next(
    input logic [MAX_CH-1:0]   req,
    input logic [CH_IDX_W-1:0] last,
    input int unsigned         width
  );
    logic [MAX_CH-1:0]   gnt;
    logic                found;
    int unsigned         idx;
    logic [CH_IDX_W-1:0] idx_s;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      if ((i <= width) && !found) begin
        idx   = (32'(last) + i) % width;
        idx_s = CH_IDX_W'(idx);
        if (req[idx_s]) begin
          gnt[idx_s] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/fe_stream_arbiter_rr_pick.sv
// Combinational rotate-priority selector: request vector plus index of the
// last channel served gives a one-hot grant and a valid flag.
module rr_pick
  import fe_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [WIDTH-1:0] grant,
  output logic             valid
);

  logic [MAX_CH-1:0]   req_ext;
  logic [CH_IDX_W-1:0] last_ext;
  logic [MAX_CH-1:0]   gnt_ext;

  // Widen to the package helper's fixed width and pick the next requester.
  always_comb begin
    req_ext              = '0;
    req_ext[WIDTH-1:0]   = req;
    last_ext             = '0;
    last_ext[IDX_W-1:0]  = last;
    gnt_ext              = rr_next(req_ext, last_ext, WIDTH);
    grant                = gnt_ext[WIDTH-1:0];
    valid                = |req;
  end

endmodule

// File: rtl/fe_stream_arbiter.sv
// Round-robin burst arbiter sharing the 32-bit data FIFO write port between
// WIDTH fei4_rx receiver FIFOs (first-word-fall-through). Zero-latency
// forwarding: read strobe, WRITE_OUT and DATA_OUT are combinational from the
// registered grant. Optional FE_ARB_WORD_CNT_EN adds the WORD_CNT port and
// its 32-bit forwarded-word counter.
module fe_stream_arbiter
  import fe_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                    BUS_CLK,
  input  logic                    BUS_RST_n,
  input  logic [WIDTH-1:0]        ENABLE,
  input  logic [WIDTH-1:0]        FIFO_EMPTY,
  input  logic [DATA_W*WIDTH-1:0] FIFO_DATA,
  output logic [WIDTH-1:0]        FIFO_READ,
  input  logic                    DOWN_READY,
  output logic                    WRITE_OUT,
  output logic [DATA_W-1:0]       DATA_OUT,
  output logic [WIDTH-1:0]        GRANT
`ifdef FE_ARB_WORD_CNT_EN
  ,
  output logic [31:0]             WORD_CNT
`endif
);

  localparam int unsigned      IDX_W      = $clog2(WIDTH);
  localparam int unsigned      CNT_W      = 8;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(WIDTH - 1);

  arb_state_e        state_q, state_d;
  logic [WIDTH-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0]  req;
  logic [WIDTH-1:0]  pick;
  logic              pick_valid;
  logic [IDX_W-1:0]  g_idx;
  logic [DATA_W-1:0] g_data;
  logic              g_enable;
  logic              g_avail;
  logic              xfer;
  logic              release_g;

  assign req = ENABLE & ~FIFO_EMPTY;

  rr_pick #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick),
    .valid (pick_valid)
  );

  // Decode the registered one-hot grant into an index and a data word; the
  // word is zero whenever nothing is granted.
  always_comb begin
    g_idx  = '0;
    g_data = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (grant_q[i]) begin
        g_idx  = IDX_W'(i);
        g_data = FIFO_DATA[i*DATA_W +: DATA_W];
      end
    end
  end

  assign g_enable  = |(grant_q & ENABLE);
  assign g_avail   = |(grant_q & ~FIFO_EMPTY);
  assign xfer      = (state_q == ARB_BUSY) && g_enable && g_avail && DOWN_READY;
  assign release_g = (xfer && (cnt_q == BURST_LAST)) || !g_avail || !g_enable;

  assign FIFO_READ = grant_q & {WIDTH{xfer}};
  assign WRITE_OUT = xfer;
  assign DATA_OUT  = g_data;
  assign GRANT     = grant_q;

  // Next-state: grant in IDLE, count and release in BUSY.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (release_g) begin
          grant_d = '0;
          last_d  = g_idx;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_n) begin
    if (!BUS_RST_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FE_ARB_WORD_CNT_EN
  logic [31:0] word_cnt_q;

  // Free-running forwarded-word counter, wraps naturally.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_n) begin
    if (!BUS_RST_n) begin
      word_cnt_q <= '0;
    end else if (xfer) begin
      word_cnt_q <= word_cnt_q + 32'd1;
    end
  end

  assign WORD_CNT = word_cnt_q;
`endif

endmodule
